// File: rtl/hamming_secded_fifo.sv
// SECDED-protected synchronous FIFO with per-lane Hamming encode/decode,
// per-word error flags, saturating error counters and error injection.
module hamming_secded_fifo #(
  parameter int DW     = 512,
  parameter int LANE_W = 64,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_fifo_wreq,
  input  logic                     i_fifo_rreq,
  input  logic [DW-1:0]            i_data,
  input  logic                     i_inj_sbe,
  input  logic                     i_inj_dbe,
  input  logic                     i_clr_cnt,
  output logic                     o_fifo_empty,
  output logic                     o_fifo_full,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_valid,
  output logic [DW-1:0]            o_data,
  output logic                     o_sbe,
  output logic                     o_dbe,
  output logic [CNT_W-1:0]         o_sbe_cnt,
  output logic [CNT_W-1:0]         o_dbe_cnt
);

  function automatic int calc_r(input int w);
    int r;
    r = 1;
    while ((1 << r) < w + r + 1) r = r + 1;
    return r;
  endfunction

  localparam int R  = calc_r(LANE_W);
  localparam int CW = LANE_W + R + 1;
  localparam int NL = DW / LANE_W;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef logic [CW-1:0]     cw_t;
  typedef logic [LANE_W-1:0] lane_t;

  typedef struct packed {
    lane_t d;
    logic  sbe;
    logic  dbe;
  } dec_t;

  function automatic cw_t enc(input lane_t d);
    cw_t  c;
    int   j;
    logic b;
    c = '0;
    j = 0;
    for (int i = 1; i < CW; i++) begin
      if ((i & (i - 1)) != 0) begin
        c[i] = d[j];
        j = j + 1;
      end
    end
    for (int k = 0; k < R; k++) begin
      b = 1'b0;
      for (int i = 1; i < CW; i++)
        if (i[k]) b = b ^ c[i];
      c[1 << k] = b;
    end
    c[0] = ^c[CW-1:1];
    return c;
  endfunction

  function automatic dec_t dec(input cw_t c);
    dec_t          res;
    logic [R-1:0]  s;
    logic          p;
    cw_t           f;
    int            j;
    s = '0;
    for (int i = 1; i < CW; i++)
      if (c[i]) s = s ^ R'(i);
    p = ^c;
    f = c;
    // s==0 with p==1 lands on position 0, the overall parity bit
    if (p) begin
      for (int i = 0; i < CW; i++)
        if (R'(i) == s) f[i] = ~f[i];
    end
    res.sbe = p;
    res.dbe = ~p & (s != '0);
    res.d   = '0;
    j = 0;
    for (int i = 1; i < CW; i++) begin
      if ((i & (i - 1)) != 0) begin
        res.d[j] = f[i];
        j = j + 1;
      end
    end
    return res;
  endfunction

  logic [NL*CW-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [LW-1:0]    level_q, level_d;
  logic             empty_q, full_q;
  logic             valid_q, sbe_q, dbe_q;
  logic [DW-1:0]    data_q;
  logic [CNT_W-1:0] sbe_cnt_q, dbe_cnt_q;

  logic             wr_acc, rd_acc;
  logic [NL*CW-1:0] wcw;
  logic [NL*CW-1:0] rcw;
  logic [DW-1:0]    rd_data;
  logic             rd_sbe, rd_dbe;
  dec_t             ld;

  assign wr_acc = i_fifo_wreq & ~full_q;
  assign rd_acc = i_fifo_rreq & ~empty_q;

  always_comb begin
    wcw = '0;
    for (int l = 0; l < NL; l++)
      wcw[l*CW +: CW] = enc(i_data[l*LANE_W +: LANE_W]);
    if (i_inj_dbe) begin
      wcw[3] = ~wcw[3];
      wcw[5] = ~wcw[5];
    end else if (i_inj_sbe) begin
      wcw[3] = ~wcw[3];
    end
  end

  assign rcw = mem_q[rptr_q];

  always_comb begin
    rd_data = '0;
    rd_sbe  = 1'b0;
    rd_dbe  = 1'b0;
    ld      = '0;
    for (int l = 0; l < NL; l++) begin
      ld = dec(rcw[l*CW +: CW]);
      rd_data[l*LANE_W +: LANE_W] = ld.d;
      rd_sbe = rd_sbe | ld.sbe;
      rd_dbe = rd_dbe | ld.dbe;
    end
  end

  always_comb begin
    level_d = level_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wptr_q] <= wcw;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      if (wr_acc) wptr_q <= wptr_q + AW'(1);
      if (rd_acc) rptr_q <= rptr_q + AW'(1);
      level_q <= level_d;
      empty_q <= (level_d == '0);
      full_q  <= (level_d == LW'(DEPTH));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sbe_q   <= 1'b0;
      dbe_q   <= 1'b0;
    end else begin
      valid_q <= rd_acc;
      if (rd_acc) begin
        data_q <= rd_data;
        sbe_q  <= rd_sbe;
        dbe_q  <= rd_dbe;
      end
    end
  end

  // Counters see the registered word, so they trail o_valid by one edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sbe_cnt_q <= '0;
      dbe_cnt_q <= '0;
    end else if (i_clr_cnt) begin
      sbe_cnt_q <= '0;
      dbe_cnt_q <= '0;
    end else begin
      if (valid_q && sbe_q && (sbe_cnt_q != '1))
        sbe_cnt_q <= sbe_cnt_q + CNT_W'(1);
      if (valid_q && dbe_q && (dbe_cnt_q != '1))
        dbe_cnt_q <= dbe_cnt_q + CNT_W'(1);
    end
  end

  assign o_fifo_empty = empty_q;
  assign o_fifo_full  = full_q;
  assign o_level      = level_q;
  assign o_valid      = valid_q;
  assign o_data       = data_q;
  assign o_sbe        = sbe_q;
  assign o_dbe        = dbe_q;
  assign o_sbe_cnt    = sbe_cnt_q;
  assign o_dbe_cnt    = dbe_cnt_q;

endmodule

// File: tb/tb_hamming_secded_fifo.sv
// Directed bench for hamming_secded_fifo: fill/drain, ECC injection,
// simultaneous ops, counter saturation/clear and mid-run reset.
module tb_hamming_secded_fifo;

  localparam int DW    = 512;
  localparam int CNT_W = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          wreq, rreq, inj_sbe, inj_dbe, clr_cnt;
  logic [DW-1:0] din;
  logic          empty, full, valid, sbe, dbe;
  logic [4:0]    level;
  logic [DW-1:0] dout;
  logic [CNT_W-1:0] sbe_cnt, dbe_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hamming_secded_fifo #(
    .DW(DW), .LANE_W(64), .DEPTH(16), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .i_fifo_wreq(wreq),
    .i_fifo_rreq(rreq),
    .i_data(din),
    .i_inj_sbe(inj_sbe),
    .i_inj_dbe(inj_dbe),
    .i_clr_cnt(clr_cnt),
    .o_fifo_empty(empty),
    .o_fifo_full(full),
    .o_level(level),
    .o_valid(valid),
    .o_data(dout),
    .o_sbe(sbe),
    .o_dbe(dbe),
    .o_sbe_cnt(sbe_cnt),
    .o_dbe_cnt(dbe_cnt)
  );

  function automatic logic [DW-1:0] rep(input logic [63:0] v);
    return {8{v}};
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    wreq = 0; rreq = 0; inj_sbe = 0; inj_dbe = 0; clr_cnt = 0;
    din = '0;
    tick(); tick();
    chk("rst_empty", DW'(empty), 1);
    chk("rst_full", DW'(full), 0);
    chk("rst_level", DW'(level), 0);
    chk("rst_valid", DW'(valid), 0);
    chk("rst_data", dout, '0);
    chk("rst_flags", DW'({sbe, dbe}), 0);
    chk("rst_cnts", DW'({sbe_cnt, dbe_cnt}), 0);
    reset_n = 1'b1;
    tick();

    // fill 16, then 2 dropped writes
    wreq = 1;
    for (int k = 0; k < 16; k++) begin
      din = rep(64'(k));
      tick();
    end
    din = rep(64'd99);
    tick(); tick();
    wreq = 0;
    chk("fill_level", DW'(level), 16);
    chk("fill_full", DW'(full), 1);
    chk("fill_empty", DW'(empty), 0);

    // drain back-to-back
    rreq = 1;
    for (int k = 0; k < 16; k++) begin
      tick();
      chk("drain_valid", DW'(valid), 1);
      chk("drain_data", dout, rep(64'(k)));
      chk("drain_flags", DW'({sbe, dbe}), 0);
    end
    rreq = 0;
    tick();
    chk("drain_idle", DW'(valid), 0);
    chk("drain_hold", dout, rep(64'd15));
    chk("drain_empty", DW'(empty), 1);
    chk("drain_level", DW'(level), 0);

    // single-bit injection
    din = '1; inj_sbe = 1; wreq = 1;
    tick();
    wreq = 0; inj_sbe = 0; rreq = 1;
    tick();
    rreq = 0;
    chk("sbe_data", dout, '1);
    chk("sbe_flags", DW'({valid, sbe, dbe}), 3'b110);
    tick();
    chk("sbe_cnt", DW'(sbe_cnt), 1);

    // double-bit injection
    din = '0; inj_dbe = 1; wreq = 1;
    tick();
    wreq = 0; inj_dbe = 0; rreq = 1;
    tick();
    rreq = 0;
    chk("dbe_data", dout, 512'h3);
    chk("dbe_flags", DW'({valid, sbe, dbe}), 3'b101);
    tick();
    chk("dbe_cnt", DW'(dbe_cnt), 1);

    // both injects: dbe wins
    din = '0; inj_sbe = 1; inj_dbe = 1; wreq = 1;
    tick();
    wreq = 0; inj_sbe = 0; inj_dbe = 0; rreq = 1;
    tick();
    rreq = 0;
    chk("both_data", dout, 512'h3);
    chk("both_flags", DW'({valid, sbe, dbe}), 3'b101);
    tick();
    chk("both_cnts", DW'({sbe_cnt, dbe_cnt}), {4'd1, 4'd2});

    // simultaneous at full
    wreq = 1;
    for (int k = 0; k < 16; k++) begin
      din = rep(64'(k + 32));
      tick();
    end
    din = rep(64'd77); rreq = 1;
    tick();
    wreq = 0; rreq = 0;
    chk("full_rw_level", DW'(level), 15);
    chk("full_rw_full", DW'(full), 0);
    chk("full_rw_data", dout, rep(64'd32));
    rreq = 1;
    for (int k = 1; k < 16; k++) begin
      tick();
      chk("full_rw_drain", dout, rep(64'(k + 32)));
    end
    rreq = 0;
    tick();
    chk("full_rw_empty", DW'(empty), 1);

    // simultaneous at empty
    din = rep(64'd5); wreq = 1; rreq = 1;
    tick();
    wreq = 0; rreq = 0;
    chk("empty_rw_level", DW'(level), 1);
    chk("empty_rw_valid", DW'(valid), 0);
    rreq = 1;
    tick();
    rreq = 0;
    chk("empty_rw_data", dout, rep(64'd5));
    chk("empty_rw_valid2", DW'(valid), 1);
    tick();

    // saturation of 4-bit counter
    for (int k = 0; k < 20; k++) begin
      din = rep(64'(k)); inj_sbe = 1; wreq = 1;
      tick();
      wreq = 0; inj_sbe = 0; rreq = 1;
      tick();
      rreq = 0;
    end
    chk("sat_last_data", dout, rep(64'd19));
    tick();
    chk("sat_sbe_cnt", DW'(sbe_cnt), 15);
    chk("sat_dbe_cnt", DW'(dbe_cnt), 2);

    // clear, then clear colliding with an increment
    clr_cnt = 1;
    tick();
    clr_cnt = 0;
    chk("clr_cnts", DW'({sbe_cnt, dbe_cnt}), 0);
    din = '0; inj_sbe = 1; wreq = 1;
    tick();
    wreq = 0; inj_sbe = 0; rreq = 1;
    tick();
    rreq = 0; clr_cnt = 1;
    chk("clr_pre_sbe", DW'({valid, sbe}), 2'b11);
    tick();
    clr_cnt = 0;
    chk("clr_prio", DW'(sbe_cnt), 0);
    tick();
    chk("clr_hold", DW'(sbe_cnt), 0);

    // reset mid-operation
    wreq = 1; inj_sbe = 1;
    for (int k = 0; k < 9; k++) begin
      din = rep(64'(k + 100));
      tick();
    end
    wreq = 0; inj_sbe = 0; rreq = 1;
    tick(); tick();
    rreq = 0;
    chk("pre_rst_level", DW'(level), 7);
    chk("pre_rst_valid", DW'(valid), 1);
    chk("pre_rst_cnt", DW'(sbe_cnt), 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_level", DW'(level), 0);
    chk("mid_rst_flags", DW'({empty, full, valid, sbe, dbe}), 5'b10000);
    chk("mid_rst_data", dout, '0);
    chk("mid_rst_cnts", DW'({sbe_cnt, dbe_cnt}), 0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("post_rst_empty", DW'(empty), 1);
    rreq = 1;
    tick();
    rreq = 0;
    chk("post_rst_noread", DW'({valid, level}), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
